// File: rtl/in_mem_arbiter.sv
// Arbiter sharing the single-port input-image BRAM between the core read port and the host port.
// Optional statistics counters are built when IN_MEM_ARB_STATS_EN is defined.
module in_mem_arbiter #(
  parameter int AW            = 12,
  parameter int HOST_MAX_WAIT = 8,
  parameter bit WRITE_PROTECT = 1'b1
) (
  input  logic          clk_sys,
  input  logic          rst_sys_n,
  input  logic          core_busy,
  input  logic          core_req,
  input  logic [AW-1:0] core_addr,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [7:0]    core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [7:0]    host_rdata,
  output logic          host_wr_drop,
  input  logic          clr_drop,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
`ifdef IN_MEM_ARB_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [31:0]   conflict_cnt,
  output logic [31:0]   host_stall_cnt
`endif
);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  owner_e        r_last_winner;
  owner_e        r_s1_owner;
  logic [7:0]    r_wait_cnt;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_s1_rd;
  logic          r_core_rvalid;
  logic          r_host_rvalid;
  logic          r_wr_drop;

  logic w_both;
  logic w_host_wins;
  logic w_any_gnt;
  logic w_drop;

  // Busy: core first, host forced through once it has waited HOST_MAX_WAIT. Idle: round-robin.
  always_comb begin
    w_both      = core_req & host_req;
    w_host_wins = host_req;
    if (w_both) begin
      if (core_busy) begin
        w_host_wins = (r_wait_cnt == 8'(HOST_MAX_WAIT));
      end else begin
        w_host_wins = (r_last_winner == OWN_CORE);
      end
    end
    core_gnt  = core_req & ~w_host_wins;
    host_gnt  = host_req & w_host_wins;
    w_any_gnt = core_gnt | host_gnt;
    w_drop    = host_gnt & host_we & core_busy & WRITE_PROTECT;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_wait_cnt    <= 8'd0;
      r_last_winner <= OWN_HOST;
    end else begin
      if (core_busy && w_both && core_gnt) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
      if (core_gnt) begin
        r_last_winner <= OWN_CORE;
      end else if (host_gnt) begin
        r_last_winner <= OWN_HOST;
      end
    end
  end

  // Two-stage pipeline: BRAM command in T+1, owner-tagged read return in T+2.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= 8'd0;
      r_s1_rd       <= 1'b0;
      r_s1_owner    <= OWN_CORE;
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_mem_en   <= w_any_gnt & ~w_drop;
      r_mem_we   <= host_gnt & host_we & ~w_drop;
      r_s1_rd    <= core_gnt | (host_gnt & ~host_we);
      r_s1_owner <= host_gnt ? OWN_HOST : OWN_CORE;
      if (w_any_gnt) begin
        r_mem_addr <= core_gnt ? core_addr : host_addr;
      end
      if (host_gnt) begin
        r_mem_wdata <= host_wdata;
      end
      r_core_rvalid <= r_s1_rd & (r_s1_owner == OWN_CORE);
      r_host_rvalid <= r_s1_rd & (r_s1_owner == OWN_HOST);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_wr_drop <= 1'b0;
    end else if (w_drop) begin
      r_wr_drop <= 1'b1;
    end else if (clr_drop) begin
      r_wr_drop <= 1'b0;
    end
  end

  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign core_rvalid  = r_core_rvalid;
  assign host_rvalid  = r_host_rvalid;
  assign core_rdata   = r_core_rvalid ? mem_rdata : 8'h00;
  assign host_rdata   = r_host_rvalid ? mem_rdata : 8'h00;
  assign host_wr_drop = r_wr_drop;

`ifdef IN_MEM_ARB_STATS_EN
  logic [31:0] r_conflict_cnt;
  logic [31:0] r_host_stall_cnt;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_conflict_cnt   <= 32'd0;
      r_host_stall_cnt <= 32'd0;
    end else if (stats_clr) begin
      r_conflict_cnt   <= 32'd0;
      r_host_stall_cnt <= 32'd0;
    end else begin
      if (w_both && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
      if (host_req && !host_gnt && (r_host_stall_cnt != 32'hFFFF_FFFF)) begin
        r_host_stall_cnt <= r_host_stall_cnt + 32'd1;
      end
    end
  end

  assign conflict_cnt   = r_conflict_cnt;
  assign host_stall_cnt = r_host_stall_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_in_mem_arbiter.sv
// Randomised self-checking bench for in_mem_arbiter against a behavioural arbitration/memory model.
// Statistics checks are included when IN_MEM_ARB_STATS_EN is defined.
module tb_in_mem_arbiter;

  localparam int AW   = 12;
  localparam int MAXW = 8;

  typedef struct {
    int         due;
    bit         host;
    logic [7:0] data;
  } rdExp_t;

  logic          clk_sys = 1'b0;
  logic          rst_sys_n;
  logic          busy;
  logic          coreReq;
  logic [AW-1:0] coreAddr;
  logic          core_gnt;
  logic          core_rvalid;
  logic [7:0]    core_rdata;
  logic          hostReq;
  logic          hostWe;
  logic [AW-1:0] hostAddr;
  logic [7:0]    hostWdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [7:0]    host_rdata;
  logic          host_wr_drop;
  logic          clrDrop;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
`ifdef IN_MEM_ARB_STATS_EN
  logic          statsClr;
  logic [31:0]   conflict_cnt;
  logic [31:0]   host_stall_cnt;
`endif

  always #5 clk_sys = ~clk_sys;

  in_mem_arbiter #(.AW(AW), .HOST_MAX_WAIT(MAXW), .WRITE_PROTECT(1'b1)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .core_busy(busy),
    .core_req(coreReq), .core_addr(coreAddr), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(hostReq), .host_we(hostWe), .host_addr(hostAddr),
    .host_wdata(hostWdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_wr_drop(host_wr_drop), .clr_drop(clrDrop),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IN_MEM_ARB_STATS_EN
    , .stats_clr(statsClr), .conflict_cnt(conflict_cnt), .host_stall_cnt(host_stall_cnt)
`endif
  );

  function automatic logic [7:0] initVal(input int i);
    if (i == 5) return 8'hA7;
    return 8'((i * 37 + 11) ^ (i >> 4));
  endfunction

  // Behavioural BRAM: registered read, one-cycle latency.
  logic [7:0] bram [0:4095];
  logic [7:0] bramQ;
  assign mem_rdata = bramQ;
  initial begin
    for (int i = 0; i < 4096; i++) bram[i] = initVal(i);
    forever begin
      @(posedge clk_sys);
      if (mem_en === 1'b1) begin
        if (mem_we === 1'b1) bram[mem_addr] <= mem_wdata;
        else bramQ <= bram[mem_addr];
      end
    end
  end

  // Reference model state
  logic [7:0]    refMem [0:4095];
  rdExp_t        mQ[$];
  bit            mLastHost;
  int            mWait;
  bit            mDrop;
  bit            mPrevEn;
  bit            mPrevWe;
  logic [AW-1:0] mPrevAddr;
  longint        mConf;
  longint        mStall;
  int            cyc;
  int            nCompared;
  int            nMismatched;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mLastHost = 1'b1;
    mWait     = 0;
    mDrop     = 1'b0;
    mPrevEn   = 1'b0;
    mPrevWe   = 1'b0;
    mPrevAddr = '0;
    mConf     = 0;
    mStall    = 0;
  endtask

  task automatic idleInputs();
    coreReq = 0; coreAddr = '0; hostReq = 0; hostWe = 0; hostAddr = '0; hostWdata = 0;
    clrDrop = 0;
`ifdef IN_MEM_ARB_STATS_EN
    statsClr = 0;
`endif
  endtask

  // Reset asserted at any point discards everything; outputs must read zero while held.
  task automatic applyReset();
    rst_sys_n = 1'b0;
    idleInputs();
    @(negedge clk_sys);
    checkOutput("rstCoreGnt", core_gnt, 0);
    checkOutput("rstHostGnt", host_gnt, 0);
    checkOutput("rstCoreRv", core_rvalid, 0);
    checkOutput("rstHostRv", host_rvalid, 0);
    checkOutput("rstRdata", {core_rdata, host_rdata}, 0);
    checkOutput("rstMemEn", mem_en, 0);
    checkOutput("rstMemWe", mem_we, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstDrop", host_wr_drop, 0);
`ifdef IN_MEM_ARB_STATS_EN
    checkOutput("rstConf", conflict_cnt, 0);
    checkOutput("rstStall", host_stall_cnt, 0);
`endif
    modelReset();
    @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
  endtask

  // One clock of comparison against the model, then advance the model by the granted access.
  task automatic applyStimulus(output bit cg, output bit hg);
    bit         both, expH, expC, dropEv, expCV, expHV;
    logic [7:0] expD;
    rdExp_t     e;
    @(negedge clk_sys);
    both = coreReq && hostReq;
    if (both) expH = busy ? (mWait == MAXW) : !mLastHost;
    else expH = hostReq;
    expC = coreReq && !expH;
    checkOutput("coreGnt", core_gnt, expC);
    checkOutput("hostGnt", host_gnt, expH);

    expCV = 0; expHV = 0; expD = 0;
    if (mQ.size() > 0 && mQ[0].due == cyc) begin
      e = mQ.pop_front();
      if (e.host) expHV = 1; else expCV = 1;
      expD = e.data;
    end
    checkOutput("coreRvalid", core_rvalid, expCV);
    checkOutput("hostRvalid", host_rvalid, expHV);
    if (expCV) checkOutput("coreRdata", core_rdata, expD);
    if (expHV) checkOutput("hostRdata", host_rdata, expD);
    checkOutput("memEn", mem_en, mPrevEn);
    checkOutput("memWe", mem_we, mPrevWe);
    if (mPrevEn) checkOutput("memAddr", mem_addr, mPrevAddr);
    checkOutput("wrDrop", host_wr_drop, mDrop);
`ifdef IN_MEM_ARB_STATS_EN
    checkOutput("conflictCnt", conflict_cnt, 32'(mConf));
    checkOutput("hostStallCnt", host_stall_cnt, 32'(mStall));
`endif

    dropEv    = expH && hostWe && busy;
    mPrevEn   = (expC || expH) && !dropEv;
    mPrevWe   = expH && hostWe && !dropEv;
    mPrevAddr = expC ? coreAddr : hostAddr;
    if (expC) mQ.push_back('{cyc + 2, 1'b0, refMem[coreAddr]});
    else if (expH && !hostWe) mQ.push_back('{cyc + 2, 1'b1, refMem[hostAddr]});
    else if (expH && !dropEv) refMem[hostAddr] = hostWdata;
    mWait = (busy && both && expC) ? mWait + 1 : 0;
    if (expC) mLastHost = 1'b0;
    else if (expH) mLastHost = 1'b1;
    mDrop = dropEv ? 1'b1 : (clrDrop ? 1'b0 : mDrop);
`ifdef IN_MEM_ARB_STATS_EN
    if (statsClr) begin
      mConf = 0; mStall = 0;
    end else begin
      if (both && mConf < 64'hFFFF_FFFF) mConf++;
      if (hostReq && !expH && mStall < 64'hFFFF_FFFF) mStall++;
    end
`endif
    cg = expC;
    hg = expH;
    cyc++;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic runBoth(input int n, input bit b);
    bit cg, hg;
    busy = b; coreReq = 1; hostReq = 1; hostWe = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(cg, hg);
      if (cg) coreAddr = coreAddr + 1'b1;
      if (hg) hostAddr = hostAddr + 1'b1;
    end
    coreReq = 0; hostReq = 0;
  endtask

  function automatic logic [AW-1:0] randAddr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, 4095));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    bit cg, hg;
    nCompared = 0; nMismatched = 0; cyc = 0; busy = 0;
    for (int i = 0; i < 4096; i++) refMem[i] = initVal(i);
    rst_sys_n = 1'b1;
    idleInputs();
    #2;
    applyReset();

    // Idle host read of address 5
    hostReq = 1; hostWe = 0; hostAddr = 12'h005;
    applyStimulus(cg, hg);
    hostReq = 0;
    for (int i = 0; i < 3; i++) applyStimulus(cg, hg);

    // Busy, both requesting: core 8 times then host, repeating
    runBoth(27, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(cg, hg);

    // Idle round-robin from a fresh reset: core first
    applyReset();
    coreAddr = 12'h000; hostAddr = 12'h100;
    runBoth(8, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(cg, hg);

    // Protected host write during a run is dropped, then the flag is cleared
    busy = 1; hostReq = 1; hostWe = 1; hostAddr = 12'h010; hostWdata = 8'h3C;
    applyStimulus(cg, hg);
    hostReq = 0; hostWe = 0;
    applyStimulus(cg, hg);
    busy = 0; coreReq = 1; coreAddr = 12'h010;
    applyStimulus(cg, hg);
    coreReq = 0;
    for (int i = 0; i < 3; i++) applyStimulus(cg, hg);
    clrDrop = 1;
    applyStimulus(cg, hg);
    clrDrop = 0;
    applyStimulus(cg, hg);

    // Interleaved core and host reads, then reset with accesses in flight
    coreAddr = 12'h000; hostAddr = 12'h020;
    runBoth(7, 1'b0);
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(cg, hg);

`ifdef IN_MEM_ARB_STATS_EN
    runBoth(5, 1'b1);
    applyStimulus(cg, hg);
    statsClr = 1;
    applyStimulus(cg, hg);
    statsClr = 0;
    applyStimulus(cg, hg);
    applyReset();
`endif

    // Randomised traffic with busy toggling and occasional drop clears
    for (int i = 0; i < 900; i++) begin
      if (i % 40 == 0) busy = 1'($urandom_range(0, 1));
      clrDrop = ($urandom_range(0, 15) == 0);
`ifdef IN_MEM_ARB_STATS_EN
      statsClr = ($urandom_range(0, 63) == 0);
`endif
      applyStimulus(cg, hg);
      if (cg || !coreReq) begin
        coreReq  = ($urandom_range(0, 3) != 0);
        coreAddr = randAddr();
      end
      if (hg || !hostReq) begin
        hostReq   = ($urandom_range(0, 2) != 0);
        hostWe    = ($urandom_range(0, 3) == 0);
        hostAddr  = randAddr();
        hostWdata = 8'($urandom_range(0, 255));
      end
    end
    idleInputs();
    for (int i = 0; i < 4; i++) applyStimulus(cg, hg);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
